// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low gfedcba patterns, capture FSM states
// and the pattern-to-digit decoder used by the loopback receiver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] code;
  } seg_dec_t;

  // legal=1 for a digit, blank=1 for all-off, both 0 for anything else
  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t r;
    r = '{legal: 1'b1, blank: 1'b0, code: 4'd0};
    case (pat)
      SEG_0:     r.code = 4'd0;
      SEG_1:     r.code = 4'd1;
      SEG_2:     r.code = 4'd2;
      SEG_3:     r.code = 4'd3;
      SEG_4:     r.code = 4'd4;
      SEG_5:     r.code = 4'd5;
      SEG_6:     r.code = 4'd6;
      SEG_7:     r.code = 4'd7;
      SEG_8:     r.code = 4'd8;
      SEG_9:     r.code = 4'd9;
      SEG_BLANK: begin r.legal = 1'b0; r.blank = 1'b1; end
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; clears to zero on reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/seg7_capture.sv
// Loopback receiver for the active-low 7-segment bus: synchronize, wait for a
// stable pattern, then decode it to a digit / blank / illegal event.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       seg_i,
  input  logic             seg_en_i,
  output logic [3:0]       value_o,
  output logic             valid_o,
  output logic             blank_o,
  output logic             illegal_o,
  output logic             locked_o,
  output logic [ERR_W-1:0] err_count_o
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] s;
  logic       en;

  sync2 #(.W(7)) u_sync_seg (.clk_i(clk_i), .rst_i(rst_i), .d_i(seg_i),    .q_o(s));
  sync2 #(.W(1)) u_sync_en  (.clk_i(clk_i), .rst_i(rst_i), .d_i(seg_en_i), .q_o(en));

  cap_state_e       state_q;
  logic [6:0]       cand_q;
  logic [7:0]       cnt_q;
  logic [3:0]       value_q;
  logic             valid_q, blank_q, illegal_q, locked_q;
  logic [ERR_W-1:0] err_q;
  seg_dec_t         dec_d;

  assign dec_d = seg_decode(cand_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cand_q    <= SEG_BLANK;
      cnt_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b1;
      illegal_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            cand_q  <= s;
            cnt_q   <= 8'd1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (s != cand_q) begin
            cand_q <= s;
            cnt_q  <= 8'd1;
          end else if (cnt_q < CNT_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            // commit: the candidate has been seen STABLE_CYCLES times in a row
            state_q <= ST_HOLD;
            if (dec_d.legal) begin
              blank_q <= 1'b0;
              if (dec_d.code != value_q || !locked_q) begin
                value_q  <= dec_d.code;
                valid_q  <= 1'b1;
                locked_q <= 1'b1;
              end
            end else if (dec_d.blank) begin
              blank_q <= 1'b1;
            end else begin
              illegal_q <= 1'b1;
              if (err_q != '1) err_q <= err_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!en) begin
            state_q <= ST_IDLE;
          end else if (s != cand_q) begin
            cand_q  <= s;
            cnt_q   <= 8'd1;
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign value_o     = value_q;
  assign valid_o     = valid_q;
  assign blank_o     = blank_q;
  assign illegal_o   = illegal_q;
  assign locked_o    = locked_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: latency, digit sweep, glitch rejection,
// illegal/saturation, blank, enable abort and asynchronous reset.
module tb_seg7_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = 7'b1111111;
  logic       seg_en = 1'b0;
  logic [3:0] value;
  logic       valid, blank, illegal, locked;
  logic [7:0] err_count;

  seg7_capture #(.STABLE_CYCLES(4), .ERR_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .seg_i(seg), .seg_en_i(seg_en),
    .value_o(value), .valid_o(valid), .blank_o(blank), .illegal_o(illegal),
    .locked_o(locked), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  int n_chk = 0, n_fail = 0;
  int vcnt = 0, icnt = 0, both = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance n edges, sampling 1ns after each edge
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
      if (illegal) icnt++;
      if (valid && illegal) both++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_value"},  value, 0);
    chk({tag, "_valid"},  valid, 0);
    chk({tag, "_blank"},  blank, 1);
    chk({tag, "_illeg"},  illegal, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"},    err_count, 0);
  endtask

  initial begin
    #12;
    chk_reset("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    seg = 7'b0010010; seg_en = 1'b1;

    // first capture: Valid visible after edge 6
    vcnt = 0; run(5);
    chk("lat_early", vcnt, 0);
    run(1);
    chk("lat_valid", valid, 1);
    chk("lat_value", value, 5);
    chk("lat_locked", locked, 1);
    chk("lat_blank", blank, 0);
    run(1);
    chk("lat_pulse1", valid, 0);

    for (int d = 0; d < 10; d++) begin
      seg = pats[d]; vcnt = 0; run(10);
      chk($sformatf("sweep%0d_n", d), vcnt, 1);
      chk($sformatf("sweep%0d_v", d), value, d);
    end
    seg = 7'b0010010; vcnt = 0; run(10);
    chk("five_new", vcnt, 1);
    vcnt = 0; run(20);
    chk("five_hold", vcnt, 0);
    seg_en = 1'b0; run(4); seg_en = 1'b1; run(10);
    chk("five_again", vcnt, 0);
    seg = 7'b0110000; run(10);
    chk("three_n", vcnt, 1);
    chk("three_v", value, 3);

    // glitch rejection
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      seg = 7'b1111001; run(2);
      seg = 7'b0100100; run(2);
    end
    chk("toggle_n", vcnt, 0);
    run(10);
    chk("toggle_settle_n", vcnt, 1);
    chk("toggle_value", value, 2);

    vcnt = 0; icnt = 0;
    for (int i = 0; i < 3; i++) begin
      seg = 7'b1010101; seg_en = 1'b1; run(8);
      seg_en = 1'b0; run(4);
    end
    chk("ill_pulses", icnt, 3);
    chk("ill_err", err_count, 3);
    chk("ill_value", value, 2);
    chk("ill_novalid", vcnt, 0);
    for (int i = 0; i < 252; i++) begin
      seg_en = 1'b1; run(8);
      seg_en = 1'b0; run(4);
    end
    chk("sat_reach", err_count, 255);
    icnt = 0;
    seg_en = 1'b1; run(8); seg_en = 1'b0; run(4);
    chk("sat_pulse", icnt, 1);
    chk("sat_hold", err_count, 255);

    vcnt = 0;
    seg = 7'b1111111; seg_en = 1'b1; run(10);
    chk("blank_lvl", blank, 1);
    chk("blank_novalid", vcnt, 0);
    chk("blank_value", value, 2);

    // enable drops while 7 is still settling
    seg = 7'b1111000; run(2);
    seg_en = 1'b0; run(8);
    chk("abort_n", vcnt, 0);
    chk("abort_value", value, 2);
    seg_en = 1'b1; run(5);
    chk("rerise_early", vcnt, 0);
    run(1);
    chk("rerise_valid", valid, 1);
    chk("rerise_value", value, 7);
    chk("rerise_blank", blank, 0);

    seg = 7'b1111001; run(3);
    #2 rst = 1'b1;
    #1 chk_reset("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    vcnt = 0; run(5);
    chk("fresh_early", vcnt, 0);
    run(1);
    chk("fresh_valid", valid, 1);
    chk("fresh_value", value, 1);
    chk("fresh_locked", locked, 1);

    chk("excl", both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
